execute: RTL

Execute stage of the pipelined MIPS core, between decode and the data-memory stage. Performs single-cycle ALU operations plus an iterative multiply/divide unit with HI/LO registers, and registers the `_EX` signal set the memory stage consumes. Raises a stall while the multiply/divide engine is busy and a dependent instruction is in EX.

---
 rtl/execute.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/execute.sv
// execute: MIPS pipeline execute stage.
// Single-cycle ALU, an iterative multiply/divide engine with HI/LO registers,
// and the registered _EX signal set consumed by the memory stage.
// Optional macro MUL_FAST_EN: when defined, mult/multu complete in one cycle on a
// combinational 32x32 multiplier; divide stays iterative in both builds.
module execute #(
    parameter int MD_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        AnyStall,
    input  logic [31:0] SrcA_ID,
    input  logic [31:0] SrcB_ID,
    input  logic [31:0] WrDat_ID,
    input  logic [2:0]  AluCtl_ID,
    input  logic [2:0]  MdOp_ID,
    input  logic        RegWrite_ID,
    input  logic        MemToReg_ID,
    input  logic        MemWrite_ID,
    input  logic        InstrVal_ID,
    input  logic        LoadB_ID,
    input  logic        StoreB_ID,
    input  logic [4:0]  WriteReg_ID,
    output logic [31:0] Result_EX,
    output logic [31:0] WrDat_EX,
    output logic        RegWrite_EX,
    output logic        MemToReg_EX,
    output logic        MemWrite_EX,
    output logic        InstrVal_EX,
    output logic        LoadB_EX,
    output logic        StoreB_EX,
    output logic [4:0]  WriteReg_EX,
    output logic        MdStall_EX,
    output logic        MdBusy
);

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULT  = 3'b001;
    localparam logic [2:0] MD_MULTU = 3'b010;
    localparam logic [2:0] MD_DIV   = 3'b011;
    localparam logic [2:0] MD_DIVU  = 3'b100;
    localparam logic [2:0] MD_MFHI  = 3'b101;
    localparam logic [2:0] MD_MFLO  = 3'b110;
    localparam logic [2:0] MD_RSVD  = 3'b111;

    localparam int              CNT_W    = $clog2(MD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } md_state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] wrdat;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        instrval;
        logic        loadb;
        logic        storeb;
        logic [4:0]  writereg;
    } ex_regs_t;

    // ------------------------------------------------------------------
    // Decode of the mul/div opcode and issue qualification
    // ------------------------------------------------------------------
    logic        issue_is_mul;
    logic        issue_is_div;
    logic        issue_signed;
    logic        md_issue;
    logic        start_eng;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign issue_is_mul = (MdOp_ID == MD_MULT) || (MdOp_ID == MD_MULTU);
    assign issue_is_div = (MdOp_ID == MD_DIV)  || (MdOp_ID == MD_DIVU);
    assign issue_signed = (MdOp_ID == MD_MULT) || (MdOp_ID == MD_DIV);
    assign md_issue     = (issue_is_mul || issue_is_div) && !MdBusy && !AnyStall && !flush;

    // The engine works on magnitudes; signs are restored in the FIX state.
    assign mag_a = (issue_signed && SrcA_ID[31]) ? (~SrcA_ID + 32'd1) : SrcA_ID;
    assign mag_b = (issue_signed && SrcB_ID[31]) ? (~SrcB_ID + 32'd1) : SrcB_ID;

`ifdef MUL_FAST_EN
    logic [63:0] fast_ext_a;
    logic [63:0] fast_ext_b;
    logic [63:0] fast_prod;

    // Low 64 bits of the extended product are the exact signed/unsigned result.
    assign fast_ext_a = issue_signed ? {{32{SrcA_ID[31]}}, SrcA_ID} : {32'd0, SrcA_ID};
    assign fast_ext_b = issue_signed ? {{32{SrcB_ID[31]}}, SrcB_ID} : {32'd0, SrcB_ID};
    assign fast_prod  = fast_ext_a * fast_ext_b;
    assign start_eng  = md_issue && !issue_is_mul;
`else
    assign start_eng  = md_issue;
`endif

    // ------------------------------------------------------------------
    // Multiply/divide engine state
    // ------------------------------------------------------------------
    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      acc_q, acc_d;   // product high half / partial remainder
    logic [31:0]      sh_q, sh_d;     // multiplier -> product low half / dividend -> quotient
    logic [31:0]      dvs_q, dvs_d;   // multiplicand / divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;   // product or quotient is negative
    logic             rneg_q, rneg_d; // remainder takes the dividend sign
    logic             dz_q, dz_d;     // divide by zero
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    // One restoring-divide step: {acc, next dividend bit} against the divisor.
    // The 32-bit subtract is exact whenever the 33-bit compare says it fits.
    logic        div_ge;
    logic [31:0] div_sub;
    assign div_ge  = {acc_q, sh_q[31]} >= {1'b0, dvs_q};
    assign div_sub = {acc_q[30:0], sh_q[31]} - dvs_q;

    // One shift-add multiply step on the {acc, sh} 64-bit pair.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, dvs_q} : 33'd0);

    // Sign-corrected results written to HI/LO in the FIX state.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    assign prod_fix = neg_q ? (~{acc_q, sh_q} + 64'd1) : {acc_q, sh_q};
    assign quo_fix  = dz_q ? 32'hFFFF_FFFF : (neg_q ? (~sh_q + 32'd1) : sh_q);
    assign rem_fix  = rneg_q ? (~acc_q + 32'd1) : acc_q;

    assign MdBusy     = (state_q != S_IDLE);
    assign MdStall_EX = MdBusy && (MdOp_ID != MD_NONE) && (MdOp_ID != MD_RSVD);

    // Engine next state: issue, iterate, sign-fix and write HI/LO.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        dvs_d    = dvs_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_eng) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    acc_d    = '0;
                    sh_d     = mag_a;
                    dvs_d    = mag_b;
                    is_div_d = issue_is_div;
                    neg_d    = issue_signed && (SrcA_ID[31] ^ SrcB_ID[31]);
                    rneg_d   = issue_signed && SrcA_ID[31];
                    dz_d     = (SrcB_ID == '0);
                end
`ifdef MUL_FAST_EN
                if (md_issue && issue_is_mul) begin
                    hi_d = fast_prod[63:32];
                    lo_d = fast_prod[31:0];
                end
`endif
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_sub : {acc_q[30:0], sh_q[31]};
                    sh_d  = {sh_q[30:0], div_ge};
                end else begin
                    acc_d = mul_sum[32:1];
                    sh_d  = {mul_sum[0], sh_q[31:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Engine registers; only reset aborts an operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            dvs_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            dvs_q    <= dvs_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // ALU and EX output registers
    // ------------------------------------------------------------------
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    ex_regs_t    ex_q, ex_d;

    // Single-cycle ALU.
    always_comb begin
        alu_res = '0;
        unique case (AluCtl_ID)
            3'b000: alu_res = SrcA_ID & SrcB_ID;
            3'b001: alu_res = SrcA_ID | SrcB_ID;
            3'b010: alu_res = SrcA_ID + SrcB_ID;
            3'b011: alu_res = SrcA_ID ^ SrcB_ID;
            3'b100: alu_res = ~(SrcA_ID | SrcB_ID);
            3'b101: alu_res = {31'd0, SrcA_ID < SrcB_ID};
            3'b110: alu_res = SrcA_ID - SrcB_ID;
            3'b111: alu_res = {31'd0, $signed(SrcA_ID) < $signed(SrcB_ID)};
            default: alu_res = '0;
        endcase
    end

    // Result select and EX register next state: stall holds, then flush clears.
    always_comb begin
        ex_result = alu_res;
        if (MdOp_ID == MD_MFHI) begin
            ex_result = hi_q;
        end else if (MdOp_ID == MD_MFLO) begin
            ex_result = lo_q;
        end
        ex_d = ex_q;
        if (!AnyStall) begin
            if (flush) begin
                ex_d = '0;
            end else begin
                ex_d.result   = ex_result;
                ex_d.wrdat    = WrDat_ID;
                ex_d.regwrite = RegWrite_ID;
                ex_d.memtoreg = MemToReg_ID;
                ex_d.memwrite = MemWrite_ID;
                ex_d.instrval = InstrVal_ID;
                ex_d.loadb    = LoadB_ID;
                ex_d.storeb   = StoreB_ID;
                ex_d.writereg = WriteReg_ID;
            end
        end
    end

    // EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign Result_EX   = ex_q.result;
    assign WrDat_EX    = ex_q.wrdat;
    assign RegWrite_EX = ex_q.regwrite;
    assign MemToReg_EX = ex_q.memtoreg;
    assign MemWrite_EX = ex_q.memwrite;
    assign InstrVal_EX = ex_q.instrval;
    assign LoadB_EX    = ex_q.loadb;
    assign StoreB_EX   = ex_q.storeb;
    assign WriteReg_EX = ex_q.writereg;

endmodule
